// File: rtl/sysid_checker.sv
// sysid_checker: reads the system ID (word 0) and build timestamp (word 1)
// from a sysid control slave, compares them with the expected values and
// reports the result.
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   start           request one check (sampled only while idle)
//   sysid_address   word address driven to the sysid slave
//   sysid_readdata  readdata returned by the sysid slave
//   busy            a check is in progress
//   done            one-cycle pulse when a check completes
//   id_ok / ts_ok   last captured ID / timestamp matched its expected value
//   pass            id_ok and ts_ok for the last completed check
//   id_value        last captured ID word
//   ts_value        last captured timestamp word
//   error_count     number of failed checks, saturating at 255
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5494A0E1,
  parameter int unsigned SETTLE_CYCLES      = 2,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [7:0]  error_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] SETTLE  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_ID = 2'd1,
    WAIT_TS = 2'd2,
    COMPARE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q;

  logic              address_d, busy_d, done_d;
  logic              id_ok_d, ts_ok_d, pass_d;
  logic [DATA_W-1:0] id_value_d, ts_value_d;
  logic [CNT_W-1:0]  error_count_d;
  logic              both_ok;

  assign both_ok = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);

  // State and registered outputs; first_q marks the first edge after reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      first_q       <= 1'b1;
      sysid_address <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      id_ok         <= 1'b0;
      ts_ok         <= 1'b0;
      pass          <= 1'b0;
      id_value      <= '0;
      ts_value      <= '0;
      error_count   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      first_q       <= 1'b0;
      sysid_address <= address_d;
      busy          <= busy_d;
      done          <= done_d;
      id_ok         <= id_ok_d;
      ts_ok         <= ts_ok_d;
      pass          <= pass_d;
      id_value      <= id_value_d;
      ts_value      <= ts_value_d;
      error_count   <= error_count_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    id_ok_d       = id_ok;
    ts_ok_d       = ts_ok;
    pass_d        = pass;
    id_value_d    = id_value;
    ts_value_d    = ts_value;
    error_count_d = error_count;

    case (state_q)
      IDLE: begin
        if (start || (AUTO_START && first_q)) begin
          state_d = WAIT_ID;
          cnt_d   = SETTLE;
        end
      end
      WAIT_ID: begin
        if (cnt_q == '0) begin
          id_value_d = sysid_readdata;
          cnt_d      = SETTLE;
          state_d    = WAIT_TS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAIT_TS: begin
        if (cnt_q == '0) begin
          ts_value_d = sysid_readdata;
          state_d    = COMPARE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      COMPARE: begin
        id_ok_d = (id_value == EXPECTED_ID);
        ts_ok_d = (ts_value == EXPECTED_TIMESTAMP);
        pass_d  = both_ok;
        done_d  = 1'b1;
        if (!both_ok && (error_count != ERR_MAX)) begin
          error_count_d = error_count + CNT_W'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Address and busy follow the state being entered so they are registered
    address_d = (state_d == WAIT_TS);
    busy_d    = (state_d != IDLE);
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Testbench for sysid_checker: instance 0 uses default parameters, instance 1
// uses SETTLE_CYCLES=0 and AUTO_START=0. Each instance talks to a slave model
// whose readdata follows the address two cycles late.
module tb_sysid_checker;

  localparam logic [31:0] ID_W   = 32'hACD51302;
  localparam logic [31:0] TS_W   = 32'h5494A0E1;
  localparam logic [31:0] BAD_ID = 32'hDEADBEEF;
  localparam logic [31:0] BAD_TS = 32'h0BAD0BAD;

  logic        clk;
  logic        reset;
  logic        start    [2];
  logic        bad_id   [2];
  logic        bad_ts   [2];
  logic        addr     [2];
  logic [31:0] rd       [2];
  logic        busy     [2];
  logic        done     [2];
  logic        id_ok    [2];
  logic        ts_ok    [2];
  logic        pass     [2];
  logic [31:0] id_value [2];
  logic [31:0] ts_value [2];
  logic [7:0]  err      [2];

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic d1, d2;

    sysid_checker #(
      .SETTLE_CYCLES ((g == 0) ? 2 : 0),
      .AUTO_START    ((g == 0) ? 1'b1 : 1'b0)
    ) u_dut (
      .clock          (clk),
      .reset          (reset),
      .start          (start[g]),
      .sysid_address  (addr[g]),
      .sysid_readdata (rd[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .id_ok          (id_ok[g]),
      .ts_ok          (ts_ok[g]),
      .pass           (pass[g]),
      .id_value       (id_value[g]),
      .ts_value       (ts_value[g]),
      .error_count    (err[g])
    );

    // Slave: readdata reflects the address seen two edges earlier
    always @(posedge clk) begin
      if (reset) begin
        d1 <= 1'b0;
        d2 <= 1'b0;
      end else begin
        d1 <= addr[g];
        d2 <= d1;
      end
    end
    assign rd[g] = d2 ? (bad_ts[g] ? BAD_TS : TS_W) : (bad_id[g] ? BAD_ID : ID_W);
  end

  // Transaction-level model: a check started at edge k captures the ID at
  // edge k+S+1, the timestamp at k+2S+2 and reports at k+2S+3.
  bit          m_active [2];
  int          m_el     [2];
  bit          m_first  [2];
  bit          m_done   [2];
  bit          m_idok   [2];
  bit          m_tsok   [2];
  bit          m_pass   [2];
  logic [31:0] m_idv    [2];
  logic [31:0] m_tsv    [2];
  logic [7:0]  m_err    [2];

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic bit auto_of(input int i);
    return (i == 0);
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int s;
      s = settle_of(i);
      if (reset) begin
        m_active[i] = 0; m_el[i] = 0; m_first[i] = 1; m_done[i] = 0;
        m_idok[i] = 0; m_tsok[i] = 0; m_pass[i] = 0;
        m_idv[i] = '0; m_tsv[i] = '0; m_err[i] = '0;
      end else begin
        m_done[i] = 0;
        if (m_active[i]) begin
          m_el[i]++;
          if (m_el[i] == s + 1) m_idv[i] = rd[i];
          if (m_el[i] == 2 * s + 2) m_tsv[i] = rd[i];
          if (m_el[i] == 2 * s + 3) begin
            m_idok[i] = (m_idv[i] == ID_W);
            m_tsok[i] = (m_tsv[i] == TS_W);
            m_pass[i] = m_idok[i] && m_tsok[i];
            if (!m_pass[i] && m_err[i] < 8'd255) m_err[i] = m_err[i] + 8'd1;
            m_done[i]   = 1;
            m_active[i] = 0;
          end
        end else if (start[i] || (auto_of(i) && m_first[i])) begin
          m_active[i] = 1;
          m_el[i]     = 0;
        end
        m_first[i] = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int  s;
      bit  m_addr;
      s      = settle_of(i);
      m_addr = m_active[i] && (m_el[i] >= s + 1) && (m_el[i] <= 2 * s + 1);
      check($sformatf("outputs%0d", i),
            80'({addr[i], busy[i], done[i], id_ok[i], ts_ok[i], pass[i],
                 id_value[i], ts_value[i], err[i]}),
            80'({m_addr, m_active[i], m_done[i], m_idok[i], m_tsok[i], m_pass[i],
                 m_idv[i], m_tsv[i], m_err[i]}));
    end
  endtask

  // One clock: model on the rising edge, compare on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_done(input int i, input int max, output int took);
    took = -1;
    for (int t = 1; t <= max; t++) begin
      tick();
      if (done[i] === 1'b1) begin
        took = t;
        break;
      end
    end
    check($sformatf("done_seen%0d", i), 80'(took != -1), 80'(1));
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  initial begin
    int took, ndone, prev, bad_gaps;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; bad_id[i] = 1'b0; bad_ts[i] = 1'b0;
    end
    repeat (3) tick();
    check("rst_id_value", 80'(id_value[0]), 80'(0));
    check("rst_err", 80'(err[0]), 80'(0));

    // Auto-start after reset: done after the 8th edge counted from release
    reset = 1'b0;
    wait_done(0, 20, took);
    check("auto_latency", 80'(took), 80'(8));
    check("auto_pass", 80'({id_ok[0], ts_ok[0], pass[0], err[0]}), 80'({3'b111, 8'd0}));
    check("no_autostart1", 80'(busy[1]), 80'(0));

    // Zero settle: timestamp captured while the slave still returns the ID
    pulse_start(1);
    wait_done(1, 10, took);
    check("s0_latency", 80'(took), 80'(3));
    check("s0_stale_ts", 80'(ts_value[1]), 80'(ID_W));
    check("s0_result", 80'({id_ok[1], ts_ok[1], pass[1], err[1]}), 80'({3'b100, 8'd1}));

    // Wrong ID word
    bad_id[0] = 1'b1;
    pulse_start(0);
    wait_done(0, 20, took);
    check("start_latency", 80'(took), 80'(7));
    check("bad_id_value", 80'(id_value[0]), 80'(BAD_ID));
    check("bad_id_result", 80'({id_ok[0], ts_ok[0], pass[0], err[0]}), 80'({3'b010, 8'd1}));

    // Second start while in WAIT_ID is ignored
    pulse_start(0);
    tick(); tick();
    pulse_start(0);
    ndone = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (done[0] === 1'b1) ndone++;
    end
    check("single_done", 80'(ndone), 80'(1));
    check("err_after_ignored", 80'(err[0]), 80'(2));

    // Wrong timestamp, then a good check holds the count
    bad_id[0] = 1'b0; bad_ts[0] = 1'b1;
    pulse_start(0);
    wait_done(0, 20, took);
    check("bad_ts_result", 80'({id_ok[0], ts_ok[0], pass[0], err[0], ts_value[0]}),
          80'({3'b100, 8'd3, BAD_TS}));
    bad_ts[0] = 1'b0;
    pulse_start(0);
    wait_done(0, 20, took);
    check("good_holds_err", 80'({pass[0], err[0]}), 80'({1'b1, 8'd3}));

    // Reset during WAIT_TS aborts the check
    pulse_start(0);
    repeat (4) tick();
    check("in_wait_ts", 80'({busy[0], addr[0]}), 80'(2'b11));
    reset = 1'b1;
    tick();
    check("abort_zero", 80'({addr[0], busy[0], done[0], id_ok[0], ts_ok[0], pass[0],
                             id_value[0], ts_value[0], err[0]}), 80'(0));
    reset = 1'b0;
    wait_done(0, 20, took);
    check("restart_latency", 80'(took), 80'(8));
    check("restart_pass", 80'({pass[0], err[0]}), 80'({1'b1, 8'd0}));

    // Held start with a failing ID: back-to-back checks, count saturates
    bad_id[0] = 1'b1;
    start[0]  = 1'b1;
    ndone = 0; prev = -1; bad_gaps = 0;
    for (int t = 0; t < 300 * 8 + 40; t++) begin
      tick();
      if (done[0] === 1'b1) begin
        if (prev >= 0 && (t - prev) != 8) bad_gaps++;
        prev = t;
        ndone++;
        if (ndone == 300) break;
      end
    end
    start[0] = 1'b0;
    check("b2b_count", 80'(ndone), 80'(300));
    check("b2b_spacing", 80'(bad_gaps), 80'(0));
    check("err_saturate", 80'(err[0]), 80'(255));
    repeat (10) tick();
    check("idle_after_b2b", 80'({busy[0], err[0]}), 80'({1'b0, 8'd255}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
